// File: rtl/fifo_reader_if.sv
// Stream bundle between the shared FIFO read port and the
// registered valid/ready output of fifo_reader.
interface fifo_reader_if #(
  parameter int DW = 32
);
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_r_data_i;
  logic          fifo_r_en_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_r_data_i,
    input  out_ready_i,
    output fifo_r_en_o,
    output out_valid_o,
    output out_data_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_r_data_i,
    output out_ready_i,
    input  fifo_r_en_o,
    input  out_valid_o,
    input  out_data_o
  );
endinterface

// File: rtl/fifo_reader.sv
// Read-side master for the shared FIFO: 2-entry prefetch buffer
// re-presenting FIFO entries as a registered valid/ready stream.
module fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_reader_if.master        bus,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [1:0]           buf_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] t_q, t_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop;
  logic                  hs;

  // Pop depends only on registered occupancy, never on ready.
  assign pop = !bus.fifo_empty_i
             && (state_q != TWO)
             && !flush_i;
  assign hs  = (state_q != EMPTY) && bus.out_ready_i;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    t_d     = t_q;
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, hs};
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (pop) begin
            state_d = ONE;
            h_d     = bus.fifo_r_data_i;
          end
        end
        ONE: begin
          unique case (1'b1)
            (pop && !hs): begin
              state_d = TWO;
              t_d     = bus.fifo_r_data_i;
            end
            (hs && !pop): begin
              state_d = EMPTY;
            end
            (pop && hs): begin
              h_d = bus.fifo_r_data_i;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (hs) begin
            state_d = ONE;
            h_d     = t_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      h_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fifo_r_en_o = pop;
  assign bus.out_valid_o = (state_q != EMPTY);
  assign bus.out_data_o  = h_q;
  assign beat_cnt_o      = cnt_q;
  assign buf_cnt_o       = state_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomised bench for fifo_reader with a
// behavioural FIFO driving the read port.
module tb_fifo_reader;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] beat;
  logic [1:0]  bufc;
  logic [3:0]  beat_w;
  logic [1:0]  bufc_w;

  always #5 clk = ~clk;

  fifo_reader_if #(.DW(DW)) bus ();
  fifo_reader_if #(.DW(DW)) bw ();

  fifo_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush_i   (flush),
    .beat_cnt_o(beat),
    .buf_cnt_o (bufc)
  );

  fifo_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (4)
  ) u_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bw),
    .flush_i   (1'b0),
    .beat_cnt_o(beat_w),
    .buf_cnt_o (bufc_w)
  );

  typedef struct {
    int          np;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic        fl;
    logic        ren;
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  bc;
    logic [15:0] bt;
  } vec_t;

  vec_t        tv[21];
  logic [31:0] q[$];
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] expq[$];
  int          cyc;
  int          viol;
  int          stab_err;
  int          pass;
  int          total;
  logic        pv, pr, pf;
  logic [31:0] pd;
  logic        pe;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass++;
  endtask

  task automatic refresh();
    bus.fifo_empty_i  = (q.size() == 0);
    bus.fifo_r_data_i = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [31:0] d);
    q.push_back(d);
    refresh();
  endtask

  // One clock: sample at the edge, update the FIFO model, return at negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (bus.fifo_r_en_o && bus.fifo_empty_i) viol++;
    pe = bus.fifo_r_en_o && !bus.fifo_empty_i;
    if (bus.out_valid_o && bus.out_ready_i) begin
      got.push_back(bus.out_data_o);
      got_cyc.push_back(cyc);
    end
    pv = bus.out_valid_o;
    pr = bus.out_ready_i;
    pd = bus.out_data_o;
    pf = flush;
    #1;
    if (rst_n && pv && !pr && !pf)
      if (!bus.out_valid_o || bus.out_data_o !== pd) stab_err++;
    if (pe) void'(q.pop_front());
    refresh();
    @(negedge clk);
  endtask

  initial begin
    int ord_err;
    int cons_err;
    int n;

    pass = 0; total = 0; cyc = 0;
    viol = 0; stab_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready_i  = 1'b0;
    bw.out_ready_i   = 1'b0;
    bw.fifo_empty_i  = 1'b1;
    bw.fifo_r_data_i = '0;
    refresh();

    tv[0]  = '{1, 32'hA1, 0, 0, 0, 1, 0, 0,     0, 0};
    tv[1]  = '{0, 0,      0, 1, 0, 0, 1, 'hA1, 1, 0};
    tv[2]  = '{0, 0,      0, 1, 0, 0, 0, 0,     0, 1};
    tv[3]  = '{2, 'h11, 'h22, 0, 0, 1, 0, 0,    0, 1};
    tv[4]  = '{1, 'h33,   0, 0, 0, 1, 1, 'h11, 1, 1};
    tv[5]  = '{0, 0,      0, 0, 0, 0, 1, 'h11, 2, 1};
    tv[6]  = '{0, 0,      0, 0, 0, 0, 1, 'h11, 2, 1};
    tv[7]  = '{0, 0,      0, 1, 0, 0, 1, 'h11, 2, 1};
    tv[8]  = '{0, 0,      0, 1, 0, 1, 1, 'h22, 1, 2};
    tv[9]  = '{0, 0,      0, 1, 0, 0, 1, 'h33, 1, 3};
    tv[10] = '{0, 0,      0, 0, 0, 0, 0, 0,     0, 4};
    tv[11] = '{2, 'h44, 'h55, 0, 0, 1, 0, 0,    0, 4};
    tv[12] = '{0, 0,      0, 0, 0, 1, 1, 'h44, 1, 4};
    tv[13] = '{1, 'h66,   0, 0, 0, 0, 1, 'h44, 2, 4};
    tv[14] = '{0, 0,      0, 1, 1, 0, 1, 'h44, 2, 4};
    tv[15] = '{0, 0,      0, 1, 0, 1, 0, 0,     0, 5};
    tv[16] = '{0, 0,      0, 1, 0, 0, 1, 'h66, 1, 5};
    tv[17] = '{1, 'h77,   0, 0, 1, 0, 0, 0,     0, 6};
    tv[18] = '{0, 0,      0, 0, 0, 1, 0, 0,     0, 6};
    tv[19] = '{0, 0,      0, 1, 0, 0, 1, 'h77, 1, 6};
    tv[20] = '{0, 0,      0, 0, 0, 0, 0, 0,     0, 7};

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid_o), 0);
    chk("rst_data",  64'(bus.out_data_o), 0);
    chk("rst_beat",  64'(beat), 0);
    chk("rst_buf",   64'(bufc), 0);
    chk("rst_ren",   64'(bus.fifo_r_en_o), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      if (tv[i].np > 0) push(tv[i].d0);
      if (tv[i].np > 1) push(tv[i].d1);
      bus.out_ready_i = tv[i].rdy;
      flush = tv[i].fl;
      #1;
      chk($sformatf("v%0d_ren", i), 64'(bus.fifo_r_en_o), 64'(tv[i].ren));
      chk($sformatf("v%0d_vld", i), 64'(bus.out_valid_o), 64'(tv[i].vld));
      if (tv[i].vld)
        chk($sformatf("v%0d_dat", i), 64'(bus.out_data_o), 64'(tv[i].dat));
      chk($sformatf("v%0d_buf", i), 64'(bufc), 64'(tv[i].bc));
      chk($sformatf("v%0d_beat", i), 64'(beat), 64'(tv[i].bt));
      tick();
      flush = 1'b0;
    end

    // Full-rate stream of 16 entries.
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 16; i++) push(32'(i));
    bus.out_ready_i = 1'b1;
    n = 0;
    while (got.size() < 16 && n < 40) begin
      tick();
      n++;
    end
    chk("stream_cnt", 64'(got.size()), 16);
    ord_err = 0;
    cons_err = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== 32'(i)) ord_err++;
      if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) cons_err++;
    end
    chk("stream_order", 64'(ord_err), 0);
    chk("stream_rate", 64'(cons_err), 0);
    chk("stream_beat", 64'(beat), 23);

    // Random back-pressure against a scoreboard.
    got.delete();
    expq.delete();
    n = 0;
    for (int c = 0; c < 20000 && got.size() < 1000; c++) begin
      if (n < 1000 && $urandom_range(0, 1) == 1) begin
        logic [31:0] d;
        d = $urandom;
        expq.push_back(d);
        push(d);
        n++;
      end
      bus.out_ready_i = ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("rand_cnt", 64'(got.size()), 1000);
    ord_err = 0;
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) ord_err++;
    chk("rand_order", 64'(ord_err), 0);
    chk("rand_empty_pop", 64'(viol), 0);
    chk("rand_stable", 64'(stab_err), 0);
    chk("rand_beat", 64'(beat), 1023);

    // Narrow counter wraps after 16 beats.
    bw.out_ready_i   = 1'b1;
    bw.fifo_r_data_i = 32'h5A;
    bw.fifo_empty_i  = 1'b0;
    repeat (17) tick();
    bw.fifo_empty_i = 1'b1;
    repeat (3) tick();
    chk("wrap_beat", 64'(beat_w), 1);
    chk("wrap_buf",  64'(bufc_w), 0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
    bus.out_ready_i = 1'b1;
    repeat (2) tick();
    chk("pre_rst_valid", 64'(bus.out_valid_o), 1);
    rst_n = 1'b0;
    q.delete();
    refresh();
    #1;
    chk("mrst_valid", 64'(bus.out_valid_o), 0);
    chk("mrst_data",  64'(bus.out_data_o), 0);
    chk("mrst_beat",  64'(beat), 0);
    chk("mrst_buf",   64'(bufc), 0);
    chk("mrst_ren",   64'(bus.fifo_r_en_o), 0);
    chk("mrst_beat_w", 64'(beat_w), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side master for the GPGPU shared `fifo`: it pops entries through the raw `r_en`/`empty`/`r_data` port and re-presents them as a registered valid/ready stream. Downstream consumers such as dispatch and writeback arbiters get full-throughput, back-pressure-safe data without combinational paths from `out_ready_i` to the FIFO. The shared FIFO has no underflow guard, so this block is responsible for never popping an empty FIFO. A two-entry prefetch buffer, a flush input and a handshake counter are included.

## Interface
- DATA_WIDTH, 32, width of FIFO entries and output data
- CNT_WIDTH, 16, width of the delivered-beat counter
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- fifo_empty_i  in  1  empty flag from the FIFO
- fifo_r_data_i  in  DATA_WIDTH  FIFO head data, combinationally valid while `fifo_empty_i`=0
- fifo_r_en_o  out  1  FIFO pop strobe; the head is consumed at the clock edge where it is 1
- out_valid_o  out  1  output stream valid
- out_ready_i  in  1  output stream ready
- out_data_o  out  DATA_WIDTH  output data, directly from a register
- flush_i  in  1  synchronous discard of all buffered entries
- beat_cnt_o  out  CNT_WIDTH  number of completed output handshakes, wraps modulo 2^CNT_WIDTH
- buf_cnt_o  out  2  occupancy of the internal buffer (0..2)

## Operation
- Storage and state:
  - Internal storage is a 2-entry buffer: head register H, drives `out_data_o`; tail register T.
  - State is the occupancy: EMPTY (0), ONE (1), TWO (2).
- Pop rule: `fifo_r_en_o = !fifo_empty_i && (buf_cnt < 2) && !flush_i`.
  - Depends only on registered occupancy, never on `out_ready_i`.
  - Never asserted while `fifo_empty_i`=1.
- `out_valid_o = (buf_cnt != 0)`.
- Handshake `hs = out_valid_o && out_ready_i`.
- Next state when `flush_i`=0:
  - EMPTY: pop → ONE, H←fifo data.
  - ONE, pop and no hs → TWO, T←fifo data.
  - ONE, hs and no pop → EMPTY.
  - ONE, pop and hs → ONE, H←fifo data.
  - ONE, neither → ONE.
  - TWO, hs → ONE, H←T. No pop is possible in TWO.
  - TWO, no hs → TWO.
- Flush:
  - `flush_i`=1 → EMPTY next cycle, regardless of hs or pop.
  - `fifo_r_en_o` is forced to 0, so no FIFO entry is lost.
  - A handshake in the flush cycle still counts in `beat_cnt_o`.
- Counter: `beat_cnt_o` increments by 1 on every hs and wraps from all-ones to 0.
- Data stability: while `out_valid_o`=1 and `out_ready_i`=0, `out_data_o` holds constant.
- Ordering: entries are delivered in FIFO order with no duplication or loss (except on flush).

## Timing
- Reset values: `fifo_r_en_o`=0 (because `buf_cnt`=0 and the FIFO is empty after its own reset), `out_valid_o`=0, `out_data_o`=0, `beat_cnt_o`=0, `buf_cnt_o`=0, H=T=0.
- Latency: with the buffer empty, a FIFO entry visible in cycle N is popped at the edge ending cycle N; `out_valid_o`=1 in cycle N+1 with that data.
- Throughput: 1 beat/cycle sustained with `out_ready_i`=1 and a non-empty FIFO. Steady state is ONE, with pop and hs every cycle.
- Back-pressure: with `out_ready_i`=0, at most 2 entries are popped, then `fifo_r_en_o`=0 until a handshake.
- Reset mid-operation: all state clears immediately (async); buffered entries are discarded.
- No combinational path from `out_ready_i` to any output.

## Test plan
- Reset, then write 0xA1 into the FIFO → `fifo_r_en_o`=1 for exactly 1 cycle; next cycle `out_valid_o`=1, `out_data_o`=0xA1; hs → `beat_cnt_o`=1, `out_valid_o`=0.
- Stream 0x00..0x0F, `out_ready_i`=1 → 16 consecutive beats in order, 1 per cycle after first-beat latency; `beat_cnt_o`=16.
- Load 0x11, 0x22, 0x33, `out_ready_i`=0 → exactly 2 pops, `buf_cnt_o`=2, FIFO still holds 0x33, `out_data_o`=0x11 stable. Raise ready → 0x11, 0x22, 0x33 in order.
- Random `out_ready_i` (50%) over 1000 entries → scoreboard exact order; `fifo_r_en_o` never 1 while `fifo_empty_i`=1.
- `buf_cnt_o`=2, pulse `flush_i` with `out_ready_i`=1 → next cycle `buf_cnt_o`=0; `beat_cnt_o` +1; no pop in the flush cycle; the next FIFO entry is delivered afterwards.
- CNT_WIDTH=4, 17 beats → `beat_cnt_o` wraps to 1. Assert `rst_n`=0 mid-stream → all outputs 0 immediately.
